decode_issue_ctrl: RTL

Issue controller sitting between the decode stage and execute. It holds one decoded instruction in an issue register and tracks in-flight register writes in a 32-entry scoreboard. It stalls upstream on read-after-write (RAW) and write-after-write (WAW) hazards, releases instructions to execute over a valid/ready handshake, and drops unissued work on a branch flush.

---
 rtl/decode_issue_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/decode_issue_ctrl.sv
// Purpose : decode-to-execute issue register with a 32-entry RAW/WAW scoreboard and branch flush.
// Latency : an instruction accepted at edge N is presented (and valid if hazard-free) in cycle N+1.
// Backpr. : in_ready_o drops while the held instruction is blocked or execute holds out_ready_i low.
//
// Ports:
//   clk, rst           clock and asynchronous active-low reset
//   in_valid_i/ready_o decode handshake; pc_i, insn_i, opcode_i, rd_i, rs1_i, rs2_i carry the instruction
//   out_valid_o/ready_i execute handshake; out_pc_o, out_insn_o, out_rd_o carry the held instruction
//   wb_valid_i, wb_rd_i writeback retire of a register write (clears its pending bit)
//   flush_i            branch redirect; drops held and offered work
//   state_o            IDLE=0, BLOCKED=1, READY=2
//   stall_cnt_o        saturating count of cycles spent in BLOCKED
module decode_issue_ctrl #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic [6:0]        opcode_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [AWIDTH-1:0] out_pc_o,
  output logic [DWIDTH-1:0] out_insn_o,
  output logic [4:0]        out_rd_o,
  input  logic              wb_valid_i,
  input  logic [4:0]        wb_rd_i,
  input  logic              flush_i,
  output logic [1:0]        state_o,
  output logic [CNTW-1:0]   stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BLOCKED = 2'd1,
    READY   = 2'd2
  } state_t;

  // Everything latched with the held instruction, including its register-use flags.
  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              rd_use;
    logic              rs1_use;
    logic              rs2_use;
  } meta_t;

  meta_t           in_meta;
  meta_t           held;
  logic            held_vld;
  logic [31:0]     pending;
  logic [31:0]     pending_nxt;
  logic [CNTW-1:0] stall_cnt;
  state_t          state;
  logic            hazard;
  logic            issue;
  logic            accept;

  // Register-use class of the offered instruction.
  always_comb begin
    in_meta         = '0;
    in_meta.pc      = pc_i;
    in_meta.insn    = insn_i;
    in_meta.rd      = rd_i;
    in_meta.rs1     = rs1_i;
    in_meta.rs2     = rs2_i;
    case (opcode_i)
      7'b0110011: begin
        in_meta.rs1_use = 1'b1;
        in_meta.rs2_use = 1'b1;
        in_meta.rd_use  = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        in_meta.rs1_use = 1'b1;
        in_meta.rd_use  = 1'b1;
      end
      7'b0100011, 7'b1100011: begin
        in_meta.rs1_use = 1'b1;
        in_meta.rs2_use = 1'b1;
      end
      7'b0110111, 7'b0010111, 7'b1101111: begin
        in_meta.rd_use  = 1'b1;
      end
      default: begin
        in_meta.rs1_use = 1'b0;
      end
    endcase
  end

  // Hazards look only at the registered scoreboard; a writeback clear is seen one cycle later.
  always_comb begin
    hazard = 1'b0;
    if (held.rs1_use && (held.rs1 != 5'd0) && pending[held.rs1]) hazard = 1'b1;
    if (held.rs2_use && (held.rs2 != 5'd0) && pending[held.rs2]) hazard = 1'b1;
    if (held.rd_use  && (held.rd  != 5'd0) && pending[held.rd])  hazard = 1'b1;
  end

  always_comb begin
    if (!held_vld)   state = IDLE;
    else if (hazard) state = BLOCKED;
    else             state = READY;
  end

  assign out_valid_o = (state == READY);
  assign issue       = out_valid_o && out_ready_i && !flush_i;
  assign in_ready_o  = flush_i || (state == IDLE) || issue;
  assign accept      = in_valid_i && in_ready_o && !flush_i;

  // Clear first, then set, so an issue and a writeback to the same rd leave it pending.
  // issue is already gated by flush_i, so a flush never sets a bit.
  always_comb begin
    pending_nxt = pending;
    if (wb_valid_i && (wb_rd_i != 5'd0)) pending_nxt[wb_rd_i] = 1'b0;
    if (issue && held.rd_use && (held.rd != 5'd0)) pending_nxt[held.rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_vld <= 1'b0;
      held     <= '0;
    end else if (flush_i) begin
      held_vld <= 1'b0;
    end else if (accept) begin
      held_vld <= 1'b1;
      held     <= in_meta;
    end else if (issue) begin
      held_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if ((state == BLOCKED) && (stall_cnt != {CNTW{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  assign state_o     = state;
  assign stall_cnt_o = stall_cnt;
  assign out_pc_o    = held.pc;
  assign out_insn_o  = held.insn;
  assign out_rd_o    = held.rd;

endmodule
